// File: rtl/button_parser_pkg.sv
// Shared helpers for the button conditioning path.
package button_parser_pkg;

   // Saturating increment: returns cur+1, never exceeding lim.
   function automatic int unsigned sat_inc(input int unsigned cur, input int unsigned lim);
      int unsigned res;
      if (cur >= lim) begin
         res = lim;
      end else begin
         res = cur + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/button_parser_debouncer.sv
// Sampled saturating-counter debouncer: one shared sample tick, one counter per channel.
// A channel is accepted once it has stayed high for PULSE_CNT_MAX consecutive ticks;
// any low cycle clears its counter at once, without waiting for a tick.
module debouncer
   import button_parser_pkg::*;
#(
   parameter int unsigned WIDTH          = 32'd4,
   parameter int unsigned SAMPLE_CNT_MAX = 32'd62500,
   parameter int unsigned PULSE_CNT_MAX  = 32'd200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] debounced
);

   localparam int unsigned SW = $clog2(SAMPLE_CNT_MAX);
   localparam int unsigned PW = $clog2(PULSE_CNT_MAX + 32'd1);

   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 32'd1);
   localparam logic [SW-1:0] SAMPLE_ONE  = SW'(1'b1);
   localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

   logic [SW-1:0] sample_cnt_r;
   logic          sample_tick_s;
   logic [PW-1:0] sat_cnt_r  [WIDTH];
   logic [PW-1:0] sat_next_s [WIDTH];

   // Tick fires in the last cycle of each sample period.
   always_comb begin
      sample_tick_s = (sample_cnt_r == SAMPLE_LAST);
   end

   // Free-running sample period counter, wraps to 0 after SAMPLE_CNT_MAX-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt_r <= '0;
      end else if (sample_tick_s) begin
         sample_cnt_r <= '0;
      end else begin
         sample_cnt_r <= sample_cnt_r + SAMPLE_ONE;
      end
   end

   // Next value per channel: clear on low, saturating step on tick while high.
   always_comb begin
      for (int unsigned i = 32'd0; i < WIDTH; i++) begin
         sat_next_s[i] = sat_cnt_r[i];
         if (!level[i]) begin
            sat_next_s[i] = '0;
         end else if (sample_tick_s) begin
            sat_next_s[i] = PW'(sat_inc(32'(sat_cnt_r[i]), PULSE_CNT_MAX));
         end else begin
            sat_next_s[i] = sat_cnt_r[i];
         end
      end
   end

   // Per-channel saturating counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 32'd0; i < WIDTH; i++) begin
            sat_cnt_r[i] <= '0;
         end
      end else begin
         for (int unsigned i = 32'd0; i < WIDTH; i++) begin
            sat_cnt_r[i] <= sat_next_s[i];
         end
      end
   end

   // A channel reads as pressed only while its counter sits at saturation.
   always_comb begin
      for (int unsigned i = 32'd0; i < WIDTH; i++) begin
         debounced[i] = (sat_cnt_r[i] == PULSE_FULL);
      end
   end

endmodule

// File: rtl/button_parser.sv
// Turns raw asynchronous push-button levels into debounced levels and
// single-cycle press pulses (synchronizer -> debouncer -> rising-edge detect).
module button_parser
   import button_parser_pkg::*;
#(
   parameter int unsigned WIDTH          = 32'd4,
   parameter int unsigned SAMPLE_CNT_MAX = 32'd62500,
   parameter int unsigned PULSE_CNT_MAX  = 32'd200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] buttons_in,
   output logic [WIDTH-1:0] buttons_debounced,
   output logic [WIDTH-1:0] buttons_pulse
);

   localparam int SYNC_STAGES = 32'sd2;

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] prev_r;

   // Synchronizer chain; only the last stage is used downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 32'sd0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= '0;
         end
      end else begin
         sync_r[0] <= buttons_in;
         for (int k = 32'sd1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
         end
      end
   end

   debouncer #(
      .WIDTH          (WIDTH),
      .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
      .PULSE_CNT_MAX  (PULSE_CNT_MAX)
   ) u_debouncer (
      .clk       (clk),
      .rst       (rst),
      .level     (sync_r[SYNC_STAGES-1]),
      .debounced (buttons_debounced)
   );

   // Remember last debounced level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r <= '0;
      end else begin
         prev_r <= buttons_debounced;
      end
   end

   // Pulse only on a 0->1 debounced transition; release produces nothing.
   always_comb begin
      buttons_pulse = buttons_debounced & ~prev_r;
   end

endmodule

// File: tb/tb_button_parser.sv
// Directed bench for button_parser with a cycle-level behavioural reference.
module tb_button_parser;

   localparam int W    = 4;
   localparam int SMAX = 10;
   localparam int PMAX = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] buttons_in;
   logic [W-1:0] buttons_debounced;
   logic [W-1:0] buttons_pulse;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference state
   logic [W-1:0] m_d1, m_d2, m_deb, m_prev;
   int           since;
   int           run_ticks [W];
   bit           m_valid = 1'b0;

   int pcnt  [W];
   int plast [W];
   int last_sc = -1;
   int wraps   = 0;

   button_parser #(
      .WIDTH          (W),
      .SAMPLE_CNT_MAX (SMAX),
      .PULSE_CNT_MAX  (PMAX)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .buttons_in        (buttons_in),
      .buttons_debounced (buttons_debounced),
      .buttons_pulse     (buttons_pulse)
   );

   always #4 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: a channel is pressed once its synchronized level has been
   // continuously high across PMAX sample ticks; ticks occur every SMAX cycles
   // after reset release, the first one SMAX edges after release.
   task automatic model_edge();
      logic [W-1:0] s2;
      bit tick;
      cyc++;
      if (rst) begin
         m_d1 = '0; m_d2 = '0; m_deb = '0; m_prev = '0;
         since = 0;
         for (int i = 0; i < W; i++) run_ticks[i] = 0;
         m_valid = 1'b1;
      end else begin
         tick  = ((since % SMAX) == SMAX - 1);
         since++;
         s2    = m_d2;
         m_d2  = m_d1;
         m_d1  = buttons_in;
         m_prev = m_deb;
         for (int i = 0; i < W; i++) begin
            if (!s2[i]) run_ticks[i] = 0;
            else if (tick) run_ticks[i]++;
            m_deb[i] = (run_ticks[i] >= PMAX);
         end
      end
   endtask

   task automatic step();
      int sc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_valid) begin
         check("debounced", int'(buttons_debounced), int'(m_deb));
         check("pulse", int'(buttons_pulse), int'(m_deb & ~m_prev));
         for (int i = 0; i < W; i++) begin
            if (buttons_pulse[i] === 1'b1) begin
               pcnt[i]++;
               plast[i] = cyc;
            end
         end
         sc = int'(dut.u_debouncer.sample_cnt_r);
         if (last_sc == SMAX - 1) begin
            check("sample_wrap", sc, 0);
            wraps++;
         end
         last_sc = sc;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int t0, base0, base1, base2, base3, lat;
      for (int i = 0; i < W; i++) begin
         pcnt[i] = 0; plast[i] = -1; run_ticks[i] = 0;
      end
      rst = 1'b1;
      buttons_in = '0;
      run(3);
      check("reset_deb", int'(buttons_debounced), 0);
      check("reset_pulse", int'(buttons_pulse), 0);
      rst = 1'b0;

      // idle
      run(100);
      check("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
      check("wrap_seen", int'(wraps > 0), 1);

      // single held press on bit 0
      buttons_in[0] = 1'b1;
      t0 = cyc; base0 = pcnt[0];
      run(100);
      check("b0_count", pcnt[0] - base0, 1);
      lat = plast[0] - t0;
      check("b0_lat_window", int'(lat >= 23 && lat <= 33), 1);
      check("b0_held_deb", int'(buttons_debounced[0]), 1);
      check("b0_others", pcnt[1] + pcnt[2] + pcnt[3], 0);
      // release: debounced drops one cycle after the synchronized fall
      buttons_in[0] = 1'b0;
      run(2);
      check("b0_rel_hold", int'(buttons_debounced[0]), 1);
      run(1);
      check("b0_rel_fall", int'(buttons_debounced[0]), 0);
      run(20);
      check("b0_no_rel_pulse", pcnt[0] - base0, 1);

      // bounce on bit 1
      base1 = pcnt[1];
      buttons_in[1] = 1'b1;
      run(15);
      buttons_in[1] = 1'b0;
      run(1);
      buttons_in[1] = 1'b1;
      t0 = cyc;
      run(22);
      check("b1_no_early", pcnt[1] - base1, 0);
      run(11);
      check("b1_count", pcnt[1] - base1, 1);
      lat = plast[1] - t0;
      check("b1_lat_window", int'(lat >= 23 && lat <= 33), 1);
      buttons_in[1] = 1'b0;
      run(5);

      // short press on bit 2
      base2 = pcnt[2];
      buttons_in[2] = 1'b1;
      run(12);
      buttons_in[2] = 1'b0;
      run(50);
      check("b2_count", pcnt[2] - base2, 0);
      check("b2_deb", int'(buttons_debounced[2]), 0);
      check("b2_cnt_zero", int'(dut.u_debouncer.sat_cnt_r[2]), 0);

      // simultaneous press on bits 0 and 3
      base0 = pcnt[0]; base3 = pcnt[3];
      buttons_in = 4'b1001;
      run(40);
      check("sim_b0_count", pcnt[0] - base0, 1);
      check("sim_b3_count", pcnt[3] - base3, 1);
      check("sim_same_cycle", plast[0], plast[3]);
      run(30);
      check("sim_b0_once", pcnt[0] - base0, 1);
      check("sim_b3_once", pcnt[3] - base3, 1);
      buttons_in = '0;
      run(5);

      // press interrupted by reset, held through release
      base0 = pcnt[0];
      buttons_in[0] = 1'b1;
      run(20);
      rst = 1'b1;
      run(3);
      check("rst_deb_low", int'(buttons_debounced), 0);
      check("rst_no_pulse", pcnt[0] - base0, 0);
      rst = 1'b0;
      t0 = cyc;
      run(40);
      check("post_rst_count", pcnt[0] - base0, 1);
      // tick restarts with the counter: ticks at release+10/20/30
      check("post_rst_latency", plast[0] - t0, 30);
      buttons_in = '0;
      run(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
